// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART transmit arbiter:
//               the arbiter state encoding, default requester count and lock
//               timeout, and the serial byte width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB  = 2'd0,    // pick the next requester
        SEND = 2'd1,    // captured byte offered to the serializer
        HOLD = 2'd2     // frame open, waiting for the owner's next byte
    } arb_state_e;

    localparam int c_def_nreq         = 2;
    localparam int c_def_lock_timeout = 1024;
    localparam int c_byte_w           = 8;

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting one position above the pointer, wrapping, and
//               reports the first asserted request.
// Revision    : 1.0 - initial release
// Ports       : i_req   [NREQ-1:0] request vector
//               i_ptr   [GW-1:0]   last granted index
//               o_found            at least one request asserted
//               o_idx   [GW-1:0]   winning index (0 when nothing found)
// ============================================================================
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = c_def_nreq,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_ptr,
    output logic            o_found,
    output logic [GW-1:0]   o_idx
);

    int          w_cand;
    logic [GW-1:0] w_cand_idx;

    always_comb begin
        o_found    = 1'b0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        // Offset 1 is the port just above the pointer; offset NREQ comes back
        // to the pointer itself, so the last owner has lowest priority.
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            w_cand_idx = GW'(w_cand);
            if (!o_found && i_req[w_cand_idx]) begin
                o_found = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter sharing one uart_tx serializer among NREQ
//               byte-stream requesters. A granted requester keeps the
//               serializer until its frame-end byte has been transferred, so
//               multi-byte messages are never interleaved.
// Revision    : 1.0 - initial release
// Options     : UART_ARB_TIMEOUT_EN - revoke a lock held idle for
//               LOCK_TIMEOUT cycles and pulse timeout_evt.
// Ports       : clk, rst_n           clock, async active-low reset
//               req_valid[NREQ]      byte valid per requester
//               req_data[8*NREQ]     bytes, requester i at [8i+7:8i]
//               req_last[NREQ]       byte ends the requester's frame
//               req_ready[NREQ]      byte accepted this cycle
//               tx_tdata/tx_tvalid   byte offered to uart_tx
//               tx_tready            uart_tx ready
//               grant                current or last owner
//               locked               multi-byte frame open
//               timeout_evt          lock revoked (timeout build only)
// ============================================================================
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = c_def_nreq,
    parameter int LOCK_TIMEOUT = c_def_lock_timeout
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [c_byte_w*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [c_byte_w-1:0]      tx_tdata,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [$clog2(NREQ)-1:0]  grant,
    output logic                     locked
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_evt
`endif
);

    localparam int c_gw = $clog2(NREQ);

    arb_state_e            state_q, state_d;
    logic [c_gw-1:0]       grant_q, grant_d;
    logic [c_byte_w-1:0]   data_q, data_d;
    logic                  last_q, last_d;
    logic                  locked_q, locked_d;

    logic                  w_found;
    logic [c_gw-1:0]       w_winner;
    logic [c_gw-1:0]       w_sel;
    logic [c_byte_w-1:0]   w_sel_byte;
    logic                  w_sel_last;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(LOCK_TIMEOUT + 1);

    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic                  evt_q, evt_d;

    assign w_cnt_inc = cnt_q + 1'b1;
`else
    logic                  w_unused_cfg;
    assign w_unused_cfg = ^LOCK_TIMEOUT;
`endif

    uart_rr_pick #(
        .NREQ (NREQ),
        .GW   (c_gw)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (grant_q),
        .o_found (w_found),
        .o_idx   (w_winner)
    );

    // A byte is only ever taken from the picker's winner (ARB) or from the
    // current owner (HOLD), so one shared mux serves both capture paths.
    assign w_sel = (state_q == ARB) ? w_winner : grant_q;

    always_comb begin
        w_sel_byte = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == c_gw'(i)) begin
                w_sel_byte = req_data[i*c_byte_w +: c_byte_w];
                w_sel_last = req_last[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        data_d    = data_q;
        last_d    = last_q;
        locked_d  = locked_q;
        req_ready = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        evt_d     = 1'b0;
`endif

        case (state_q)
            ARB: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    data_d              = w_sel_byte;
                    last_d              = w_sel_last;
                    grant_d             = w_winner;
                    state_d             = SEND;
                end
            end

            SEND: begin
                if (tx_tready) begin
                    if (last_q) begin
                        state_d  = ARB;
                        locked_d = 1'b0;
                    end else begin
                        state_d  = HOLD;
                        locked_d = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end

            HOLD: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    data_d  = w_sel_byte;
                    last_d  = w_sel_last;
                    state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (w_cnt_inc == c_cnt_w'(LOCK_TIMEOUT)) begin
                    // Revoke: grant_q stays put, so the next ARB scan
                    // naturally starts past the idle owner.
                    state_d  = ARB;
                    locked_d = 1'b0;
                    evt_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
`endif
            end

            default: begin
                state_d = ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            grant_q  <= c_gw'(NREQ - 1);
            data_q   <= '0;
            last_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            last_q   <= last_d;
            locked_q <= locked_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign timeout_evt = evt_q;
`endif

    assign tx_tvalid = (state_q == SEND);
    assign tx_tdata  = data_q;
    assign grant     = grant_q;
    assign locked    = locked_q;

endmodule : uart_tx_arb
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb (NREQ=2, LOCK_TIMEOUT=16).
//               A cycle table covers reset, single-byte frames, alternation
//               and a locked three-byte frame; hand sequences cover a long
//               serializer stall, a reset during SEND and the lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [0:0]  grant;
    logic        locked;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_evt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arb #(
        .NREQ         (2),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .grant       (grant),
        .locked      (locked)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_evt (timeout_evt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [15:0] rd;
        logic [1:0]  rl;
        logic        tr;
        logic [1:0]  e_ready;
        logic        e_tvalid;
        logic [7:0]  e_tdata;   // checked only when e_tvalid=1
        logic        e_grant;
        logic        e_locked;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge and settle, so checks see the
    // combinational outputs of the cycle that ends at the next rising edge.
    task automatic step(input logic [1:0] rv, input logic [15:0] rd,
                        input logic [1:0] rl, input logic tr);
        @(negedge clk);
        req_valid = rv;
        req_data  = rd;
        req_last  = rl;
        tx_tready = tr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        tx_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst tvalid", 32'(tx_tvalid), 32'h0);
        check("rst tdata",  32'(tx_tdata),  32'h00);
        check("rst ready",  32'(req_ready), 32'h0);
        check("rst locked", 32'(locked),    32'h0);
        check("rst grant",  32'(grant),     32'h1);
`ifdef UART_ARB_TIMEOUT_EN
        check("rst evt",    32'(timeout_evt), 32'h0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        tx_tready = 1'b1;

        //           rv     rd        rl     tr    ready  tv    tdata  g     lk
        vecs[0]  = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 16'h0041, 2'b01, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 16'h0041, 2'b01, 1'b0, 2'b00, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 16'h0041, 2'b01, 1'b1, 2'b00, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 16'h0041, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        // both ports saturated with single-byte frames: 1,0,1,0
        vecs[5]  = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b00, 1'b1, 8'h20, 1'b1, 1'b0};
        vecs[7]  = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b00, 1'b1, 8'h10, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b00, 1'b1, 8'h20, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 16'h2010, 2'b11, 1'b1, 2'b00, 1'b1, 8'h10, 1'b0, 1'b0};
        // port 1 frame A0,A1,A2 while port 0 keeps a single-byte frame valid
        vecs[13] = '{2'b11, 16'hA055, 2'b01, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{2'b11, 16'hA055, 2'b01, 1'b1, 2'b00, 1'b1, 8'hA0, 1'b1, 1'b0};
        vecs[15] = '{2'b11, 16'hA155, 2'b01, 1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[16] = '{2'b11, 16'hA155, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA1, 1'b1, 1'b1};
        vecs[17] = '{2'b11, 16'hA155, 2'b01, 1'b1, 2'b00, 1'b1, 8'hA1, 1'b1, 1'b1};
        vecs[18] = '{2'b11, 16'hA255, 2'b11, 1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[19] = '{2'b11, 16'hA255, 2'b11, 1'b1, 2'b00, 1'b1, 8'hA2, 1'b1, 1'b1};
        vecs[20] = '{2'b11, 16'hA255, 2'b11, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[21] = '{2'b11, 16'hA255, 2'b11, 1'b1, 2'b00, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[22] = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rv, vecs[i].rd, vecs[i].rl, vecs[i].tr);
            check($sformatf("row%0d ready", i),  32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("row%0d tvalid", i), 32'(tx_tvalid), 32'(vecs[i].e_tvalid));
            if (vecs[i].e_tvalid)
                check($sformatf("row%0d tdata", i), 32'(tx_tdata), 32'(vecs[i].e_tdata));
            check($sformatf("row%0d grant", i),  32'(grant),     32'(vecs[i].e_grant));
            check($sformatf("row%0d locked", i), 32'(locked),    32'(vecs[i].e_locked));
        end

        // ---- serializer stall: tready low for 50 cycles ----
        step(2'b10, 16'h7700, 2'b10, 1'b1);
        check("stall accept ready", 32'(req_ready), 32'h2);
        for (int k = 0; k < 50; k++) begin
            step(2'b11, 16'h7712, 2'b11, 1'b0);
            check($sformatf("stall%0d tvalid", k), 32'(tx_tvalid), 32'h1);
            check($sformatf("stall%0d tdata", k),  32'(tx_tdata),  32'h77);
            check($sformatf("stall%0d ready", k),  32'(req_ready), 32'h0);
        end
        step(2'b00, 16'h7712, 2'b11, 1'b1);
        check("stall release tvalid", 32'(tx_tvalid), 32'h1);
        check("stall release tdata",  32'(tx_tdata),  32'h77);
        step(2'b00, 16'h0000, 2'b00, 1'b1);
        check("post xfer tvalid", 32'(tx_tvalid), 32'h0);
        check("post xfer grant",  32'(grant),     32'h1);

        // ---- reset asserted mid-frame in SEND ----
        step(2'b01, 16'h00C0, 2'b00, 1'b1);
        check("mf accept ready", 32'(req_ready), 32'h1);
        step(2'b00, 16'h00C0, 2'b00, 1'b1);
        check("mf send0 tdata", 32'(tx_tdata), 32'hC0);
        step(2'b01, 16'h00C1, 2'b00, 1'b1);
        check("mf hold ready",  32'(req_ready), 32'h1);
        check("mf hold locked", 32'(locked),    32'h1);
        step(2'b00, 16'h00C1, 2'b00, 1'b0);
        check("mf send1 tvalid", 32'(tx_tvalid), 32'h1);
        check("mf send1 tdata",  32'(tx_tdata),  32'hC1);
        check("mf send1 locked", 32'(locked),    32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst tvalid", 32'(tx_tvalid), 32'h0);
        check("arst locked", 32'(locked),    32'h0);
        check("arst grant",  32'(grant),     32'h1);
        check("arst ready",  32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 16'h00D0, 2'b01, 1'b1);
        check("after rst ready",  32'(req_ready), 32'h1);
        check("after rst grant",  32'(grant),     32'h1);
        check("after rst tvalid", 32'(tx_tvalid), 32'h0);
        step(2'b00, 16'h00D0, 2'b01, 1'b1);
        check("after rst send tvalid", 32'(tx_tvalid), 32'h1);
        check("after rst send tdata",  32'(tx_tdata),  32'hD0);
        check("after rst send grant",  32'(grant),     32'h0);

`ifdef UART_ARB_TIMEOUT_EN
        // ---- lock timeout with LOCK_TIMEOUT=16 ----
        do_reset();
        step(2'b01, 16'h9933, 2'b10, 1'b1);
        check("to accept ready", 32'(req_ready), 32'h1);
        step(2'b10, 16'h9933, 2'b10, 1'b1);
        check("to send tdata", 32'(tx_tdata), 32'h33);
        for (int k = 0; k < 16; k++) begin
            step(2'b10, 16'h9933, 2'b10, 1'b1);
            check($sformatf("to hold%0d ready", k),  32'(req_ready),   32'h1);
            check($sformatf("to hold%0d locked", k), 32'(locked),      32'h1);
            check($sformatf("to hold%0d evt", k),    32'(timeout_evt), 32'h0);
        end
        step(2'b10, 16'h9933, 2'b10, 1'b1);
        check("to revoke evt",    32'(timeout_evt), 32'h1);
        check("to revoke locked", 32'(locked),      32'h0);
        check("to revoke ready",  32'(req_ready),   32'h2);
        step(2'b00, 16'h9933, 2'b10, 1'b1);
        check("to after evt",    32'(timeout_evt), 32'h0);
        check("to after tvalid", 32'(tx_tvalid),   32'h1);
        check("to after tdata",  32'(tx_tdata),    32'h99);
        check("to after grant",  32'(grant),       32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_arb
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single `uart_tx` serializer among NREQ byte-stream requesters, for example the core output stream, loader acknowledgements and debug dump. Requesters present bytes with a valid/ready handshake and a frame-end marker. Once granted, a requester keeps the serializer until its frame ends, so multi-byte messages are never interleaved. The block sits between the requesters and `uart_tx`, and drives that module's `tdata`/`tvalid`/`tready` interface directly.

## Interface
- NREQ, 2: number of requesters; must be at least 2.
- LOCK_TIMEOUT, 1024: idle cycles a locked requester may leave its frame open before the grant is revoked. Used only with the timeout feature.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  byte valid, one bit per requester
- req_data  in  8*NREQ  flattened bytes; requester i uses bits [8i+7:8i]
- req_last  in  NREQ  this byte ends the requester's frame
- req_ready  out  NREQ  byte accepted this cycle (combinational from state and grant)
- tx_tdata  out  8  byte to `uart_tx`
- tx_tvalid  out  1  byte offered to `uart_tx`
- tx_tready  in  1  `uart_tx` tready
- grant  out  $clog2(NREQ)  current or last owner
- locked  out  1  a frame is open
- timeout_evt  out  1  one-cycle pulse on grant revocation; only present with UART_ARB_TIMEOUT_EN

## Operation
- Reset values: tx_tvalid=0, tx_tdata=8'h00, req_ready=0, locked=0, grant=NREQ-1 (so port 0 has first priority), timeout_evt=0, state ARB.
- Reset is asynchronous. A reset asserted mid-frame drops the captured byte and the lock immediately; no partial byte is replayed.
- ARB state:
  - Winner = first asserted req_valid scanning from (grant+1) mod NREQ upward, wrapping.
  - The winner's req_ready=1 in the same cycle, and its byte and last flag are captured.
  - grant is updated to the winner; next state is SEND.
  - No valid requests: stay in ARB with all req_ready=0.
- SEND state:
  - tx_tvalid=1 and tx_tdata holds the captured byte; req_ready=0.
  - A transfer occurs when tx_tvalid && tx_tready.
  - On transfer, tx_tvalid=0 next cycle. If the captured last flag is 1, go to ARB with locked=0; otherwise go to HOLD with locked=1.
- HOLD state:
  - req_ready[grant]=1 and all other req_ready=0.
  - When req_valid[grant] is asserted, capture the byte and go to SEND.
  - Other requesters are ignored while their req_valid stays high.
- locked=1 from the first byte of a multi-byte frame until its last byte transfers.
- A single-byte frame (req_last=1 on the first byte) never enters HOLD and never asserts locked.
- Fairness: the pointer advances only at frame end or revocation. With every port saturated, grants cycle 0,1,…,NREQ-1,0.

## Timing
- Request-to-offer latency: a byte accepted in ARB or HOLD in cycle t gives tx_tvalid=1 in cycle t+1.
- `uart_tx` drops tready the cycle after the transfer and raises it in the cycle it returns to idle.
- tx_tvalid is never asserted in the cycle after a transfer.
- Minimum spacing between offers is 2 cycles. Actual spacing is set by `uart_tx` (10×WAIT_DIV cycles per byte).
- tx_tready=1 while tx_tvalid=0 has no effect.
- tx_tvalid is held until the transfer; tx_tdata is stable while tx_tvalid=1.
- A requester asserting req_valid in the same cycle the current frame ends is considered in the next ARB cycle, under the updated pointer.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(LOCK_TIMEOUT+1) clears on entry to HOLD and on every accepted byte.
  - It increments each HOLD cycle without req_valid[grant].
  - When it reaches LOCK_TIMEOUT: go to ARB, locked=0, pointer advances past grant, and timeout_evt pulses for 1 cycle.
- UART_ARB_TIMEOUT_EN undefined: HOLD waits indefinitely, and the timeout_evt port and the counter do not exist.

## Structure
- Shared package `uart_arb_pkg`:
  - state enum {ARB, SEND, HOLD}
  - default NREQ and LOCK_TIMEOUT constants
  - byte width constant of 8
- One sub-module, `uart_rr_pick`: a combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the found flag and the winner index. It is instanced once in ARB.
- Capture register, FSM and timeout counter live in `uart_tx_arb`.

## Test plan
- Reset, then port 0 sends 8'h41 with last=1 → tx_tdata=8'h41 and tx_tvalid high 1 cycle after req_ready. Back in ARB, grant=0, locked=0.
- Ports 0 and 1 both hold valid single-byte frames continuously → transfer order alternates 0,1,0,1; no port is starved.
- Port 1 frame 8'hA0,8'hA1,8'hA2 (last on A2) while port 0 is continuously valid → the serializer sees A0,A1,A2 contiguously, then port 0. locked=1 from the transfer of A0 through the transfer of A2.
- tx_tready held low for 50 cycles while tx_tvalid=1 → tx_tdata is stable and no requester gets req_ready.
- With UART_ARB_TIMEOUT_EN and LOCK_TIMEOUT=16: port 0 sends 1 byte with last=0 then goes silent → timeout_evt pulses 16 cycles after HOLD entry, then waiting port 1 is granted.
- rst_n asserted in SEND with tx_tvalid=1 → tx_tvalid=0 immediately; after release, state ARB and grant=NREQ-1.
